ce_gen: RTL and testbench
=========================

Name: ce_gen

Overview:
- Clock-enable pulse generator that sits directly upstream of the 4-bit cascadable counter and drives its ce input.
- Produces single-cycle ce pulses in one of two modes:
  - periodic: one pulse every DIV clocks;
  - single-step: one pulse per rising edge of an asynchronous step input (a button).
- Also counts the pulses it has issued, for lab readout.

Parameters:
- DIV_W, 16: width of the div input and of the internal period counter.
- CNT_W, 8: width of the issued-pulse counter n_ce.

Ports:
- clk  in  1: system clock; all state changes on its rising edge.
- r_n  in  1: reset, asynchronous, active-low.
- en  in  1: run enable, synchronous. 1 = generate pulses in the selected mode; 0 = idle.
- mode  in  1: 0 = periodic, 1 = single-step.
- div  in  DIV_W: period in clk cycles for periodic mode. Values 0 and 1 both mean a pulse every cycle.
- step  in  1: asynchronous step request, already debounced externally.
- clr  in  1: synchronous clear of n_ce.
- ce  out  1: registered clock-enable pulse, high for exactly one cycle per event.
- busy  out  1: registered; 1 while the block is in RUN_P or RUN_S.
- phase  out  DIV_W: current period-counter value (counts down to 0).
- n_ce  out  CNT_W: number of ce pulses issued since reset or clr; wraps.

Behaviour:
- Reset (r_n=0, asynchronous):
  - ce=0, busy=0, phase=0, n_ce=0, state=IDLE, latched period=1.
  - All three step synchronizer/history flops are set to 1, so a step held high across reset release produces no pulse.
- Effective period: D = max(div,1). It is latched on entry to RUN_P and at every wrap (phase==0). Mid-period changes of div take effect only at the next wrap.
- State machine, evaluated on each clk edge:
  - IDLE: en=1 & mode=0 -> RUN_P, phase<=D-1. en=1 & mode=1 -> RUN_S.
  - RUN_P: en=0 -> IDLE. mode=1 -> RUN_S. Otherwise phase decrements; at 0 it reloads D-1.
  - RUN_S: en=0 -> IDLE. mode=0 -> RUN_P, phase<=D-1.
  - Any transition into IDLE forces phase<=0.
- Periodic timing:
  - Let en be sampled high at edge E0.
  - ce is high in the cycle after edges E0+D-1, E0+2D-1, E0+3D-1, and so on.
  - This gives exactly 1 high cycle per D cycles. D=1 gives ce high every cycle after E0. D=8 gives 7 low / 1 high.
- Step timing:
  - step passes through a 2-flop synchronizer, then a history flop.
  - A rising edge of step first sampled at edge S0 makes ce high for exactly the one cycle after edge S0+2, if the state is RUN_S at that edge.
  - Step edges arriving in IDLE or RUN_P are discarded. They are never queued.
- Simultaneous events:
  - en falling on the same edge as a pending pulse: no pulse; en has priority.
  - A mode switch reloads phase and drops any pulse due on that edge.
  - clr on the same edge as a ce pulse: n_ce<=1. Otherwise clr gives n_ce<=0.
- n_ce increments on every edge where ce is driven to 1 and wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-period: all outputs drop to their reset values immediately, without waiting for clk.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, RUN_P=2'd1, RUN_S=2'd2);
  - the MODE_PERIODIC and MODE_STEP constants.
- One natural sub-module: sync_edge. It is the 2-flop synchronizer plus rising-edge detector, with a reset-to-1 option. The top block instantiates it for step, and it is reusable for other button inputs.

Test Plan:
- Reset hold: r_n=0 with arbitrary inputs -> ce=0, busy=0, phase=0, n_ce=0. Release r_n with step=1 held -> no ce pulse within 10 cycles.
- Periodic D=8: mode=0, div=8, en rises at edge 0 -> ce high only after edges 7, 15, 23. After 3 pulses n_ce=3; phase sequence is 7..0 repeating.
- div=0 and div=1: en=1, mode=0 -> ce high every cycle. Change div 1->4 mid-run -> the new period starts at the next wrap; gaps of 3 low cycles follow.
- Step mode: mode=1, en=1; raise step for 5 cycles at edge 10 -> exactly one ce pulse, in the cycle after edge 12. A second step edge at edge 30 gives a second pulse; a step edge while en=0 gives nothing.
- Priority/boundary:
  - en falls on the edge where the pulse is due -> no pulse, state goes to IDLE.
  - clr coinciding with a pulse -> n_ce=1.
  - n_ce at 255 plus one pulse -> n_ce=0.
- Async reset mid-run: div=8, pulse 4 cycles away; pulse r_n low between clock edges -> outputs clear immediately. After release with en=1, the first ce comes 8 cycles after the first sampling edge.

Source files
------------

// File: rtl/ce_gen_pkg.sv
// Shared encodings for the clock-enable generator: FSM states and mode select values.
package ce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_P = 2'd1,
    RUN_S = 2'd2
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_STEP     = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop; flags a rising edge of an asynchronous input.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic r_n,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // A reset value of 1 keeps an input held high across reset from reading as an edge.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/ce_gen.sv
// Clock-enable pulse generator: periodic (every max(div,1) clocks) or one pulse per step press.
module ce_gen
  import ce_gen_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             en,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic             step,
  input  logic             clr,
  output logic             ce,
  output logic             busy,
  output logic [DIV_W-1:0] phase,
  output logic [CNT_W-1:0] n_ce
);

  state_e           state_q;
  logic [DIV_W-1:0] phase_q;
  logic             ce_q;
  logic             busy_q;
  logic [CNT_W-1:0] n_ce_q;

  logic [DIV_W-1:0] reload;
  logic             step_rise;
  logic             pulse;

  sync_edge #(.RST_VAL(1'b1)) u_step_sync (
    .clk    (clk),
    .r_n    (r_n),
    .d_i    (step),
    .rise_o (step_rise)
  );

  assign reload = (div == '0) ? '0 : div - DIV_W'(1);

  // The pulse fires on the edge where phase is driven to 0; a mode switch never pulses.
  always_comb begin
    pulse = 1'b0;
    if (en) begin
      case (state_q)
        IDLE:    pulse = (mode == MODE_PERIODIC) && (reload == '0);
        RUN_P: begin
          if (mode == MODE_PERIODIC)
            pulse = (phase_q == '0) ? (reload == '0) : (phase_q == DIV_W'(1));
        end
        RUN_S: begin
          if (mode == MODE_STEP)
            pulse = step_rise;
        end
        default: pulse = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      n_ce_q  <= '0;
    end else begin
      ce_q <= pulse;

      if (clr)
        n_ce_q <= pulse ? CNT_W'(1) : '0;
      else if (pulse)
        n_ce_q <= n_ce_q + CNT_W'(1);

      if (!en) begin
        state_q <= IDLE;
        phase_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b1;
            if (mode == MODE_PERIODIC) begin
              state_q <= RUN_P;
              phase_q <= reload;
            end else begin
              state_q <= RUN_S;
            end
          end
          RUN_P: begin
            if (mode == MODE_STEP)
              state_q <= RUN_S;
            else
              phase_q <= (phase_q == '0) ? reload : phase_q - DIV_W'(1);
          end
          RUN_S: begin
            if (mode == MODE_PERIODIC) begin
              state_q <= RUN_P;
              phase_q <= reload;
            end
          end
          default: begin
            state_q <= IDLE;
            phase_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ce    = ce_q;
  assign busy  = busy_q;
  assign phase = phase_q;
  assign n_ce  = n_ce_q;

endmodule

// File: tb/tb_ce_gen.sv
// Self-checking bench for ce_gen: vector table plus hand-written corner sequences.
module tb_ce_gen;

  logic        clk = 1'b0;
  logic        r_n = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] div = 16'd1;
  logic        step = 1'b0;
  logic        clr = 1'b0;
  logic        ce;
  logic        busy;
  logic [15:0] phase;
  logic [7:0]  n_ce;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ce_gen #(.DIV_W(16), .CNT_W(8)) dut (
    .clk   (clk),
    .r_n   (r_n),
    .en    (en),
    .mode  (mode),
    .div   (div),
    .step  (step),
    .clr   (clr),
    .ce    (ce),
    .busy  (busy),
    .phase (phase),
    .n_ce  (n_ce)
  );

  typedef struct {
    logic  exp_ce;
    string tag;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    string       name;
    logic        mode_v;
    logic        en_v;
    logic [15:0] div_v;
    logic [31:0] step_m;
    logic [31:0] ce_m;
    logic [7:0]  n_end;
    logic        busy_end;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: one expected ce value per clock edge, compared 1 time unit after it.
  always @(posedge clk) begin : sb_check
    sb_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, 32'(ce), 32'(e.exp_ce));
    end
  end

  task automatic cyc(input logic exp_ce, input string tag);
    sb.push_back('{exp_ce, tag});
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    r_n = 1'b0; en = 1'b0; mode = 1'b0; step = 1'b0; clr = 1'b0; div = 16'd1;
    @(posedge clk);
    #2;
    r_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{"per_d8",   1'b0, 1'b1, 16'd8,  32'h0000_0000, 32'h8080_8080, 8'd4,  1'b1};
    vt[1] = '{"per_d1",   1'b0, 1'b1, 16'd1,  32'h0000_0000, 32'hFFFF_FFFF, 8'd32, 1'b1};
    vt[2] = '{"per_d0",   1'b0, 1'b1, 16'd0,  32'h0000_0000, 32'hFFFF_FFFF, 8'd32, 1'b1};
    vt[3] = '{"per_d3",   1'b0, 1'b1, 16'd3,  32'h0000_0000, 32'h2492_4924, 8'd10, 1'b1};
    vt[4] = '{"step_two", 1'b1, 1'b1, 16'd5,  32'h0070_7C00, 32'h0040_1000, 8'd2,  1'b1};
    vt[5] = '{"step_inP", 1'b0, 1'b1, 16'd16, 32'h0000_0F00, 32'h8000_8000, 8'd2,  1'b1};
    vt[6] = '{"step_off", 1'b1, 1'b0, 16'd4,  32'h0000_0F00, 32'h0000_0000, 8'd0,  1'b0};

    // Reset hold with arbitrary inputs, then release with step held high.
    en = 1'b1; mode = 1'b0; div = 16'd5; step = 1'b1; clr = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_n_ce", 32'(n_ce), 32'd0);
    mode = 1'b1; clr = 1'b0; r_n = 1'b1;
    for (int k = 0; k < 10; k++) cyc(1'b0, "rst_step_hold");
    $display("sequence reset_hold done");

    for (int v = 0; v < 7; v++) begin
      do_reset();
      mode = vt[v].mode_v; en = vt[v].en_v; div = vt[v].div_v;
      for (int k = 0; k < 32; k++) begin
        step = vt[v].step_m[k];
        cyc(vt[v].ce_m[k], vt[v].name);
      end
      chk({vt[v].name, "_n_ce"}, 32'(n_ce), 32'(vt[v].n_end));
      chk({vt[v].name, "_busy"}, 32'(busy), 32'(vt[v].busy_end));
      step = 1'b0;
      $display("vector %s applied", vt[v].name);
    end

    // Phase counts 7..0 and repeats for D=8.
    do_reset();
    div = 16'd8; en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      chk("phase_seq", 32'(phase), 32'(7 - (k % 8)));
    end
    $display("sequence phase_seq done");

    // div 1 -> 4 mid-run takes effect at the next wrap.
    do_reset();
    div = 16'd1; en = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1'b1, "div_chg_pre");
    div = 16'd4;
    for (int k = 0; k < 8; k++) cyc((k % 4) == 3, "div_chg_post");
    $display("sequence div_change done");

    // en falling on the pulse edge wins.
    do_reset();
    div = 16'd8; en = 1'b1;
    for (int k = 0; k < 7; k++) cyc(1'b0, "en_fall_pre");
    en = 1'b0;
    cyc(1'b0, "en_fall_edge");
    chk("en_fall_busy", 32'(busy), 32'd0);
    chk("en_fall_phase", 32'(phase), 32'd0);
    for (int k = 0; k < 10; k++) cyc(1'b0, "en_fall_after");
    $display("sequence en_priority done");

    // clr coinciding with a pulse leaves n_ce=1; clr alone gives 0.
    do_reset();
    div = 16'd2; en = 1'b1;
    cyc(1'b0, "clr_e0");
    clr = 1'b1;
    cyc(1'b1, "clr_e1");
    chk("clr_with_pulse", 32'(n_ce), 32'd1);
    cyc(1'b0, "clr_e2");
    chk("clr_no_pulse", 32'(n_ce), 32'd0);
    clr = 1'b0;
    cyc(1'b1, "clr_e3");
    chk("clr_after", 32'(n_ce), 32'd1);
    $display("sequence clr done");

    // n_ce wraps from 255 to 0.
    do_reset();
    div = 16'd1; en = 1'b1;
    repeat (255) @(posedge clk);
    #2;
    chk("wrap_255", 32'(n_ce), 32'd255);
    @(posedge clk);
    #2;
    chk("wrap_0", 32'(n_ce), 32'd0);
    $display("sequence n_ce_wrap done");

    // Mode switches drop the pulse due on that edge.
    do_reset();
    div = 16'd1; en = 1'b1; mode = 1'b0;
    cyc(1'b1, "msw_p0");
    cyc(1'b1, "msw_p1");
    mode = 1'b1;
    cyc(1'b0, "msw_to_s");
    mode = 1'b0;
    cyc(1'b0, "msw_to_p");
    cyc(1'b1, "msw_p_resume");
    chk("msw_busy", 32'(busy), 32'd1);
    $display("sequence mode_switch done");

    // Asynchronous reset between edges, four cycles before a pulse.
    do_reset();
    div = 16'd8; en = 1'b1; mode = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1'b0, "ar_pre");
    #1 r_n = 1'b0;
    #1;
    chk("ar_ce", 32'(ce), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_phase", 32'(phase), 32'd0);
    chk("ar_n_ce", 32'(n_ce), 32'd0);
    #1 r_n = 1'b1;
    for (int k = 0; k < 8; k++) cyc(k == 7, "ar_post");
    $display("sequence async_reset done");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
